// File: rtl/vga_grid_ctrl_if.sv
// Memory-side bus of the VGA grid controller: board RAM, sprite ROM and
// background ROM. All three memories return data one clock after the address.
interface vga_grid_ctrl_if #(
    parameter int AW = 11
);
    logic [AW-1:0] board_addr;
    logic [4:0]    board_data;
    logic [17:0]   sprite_addr;
    logic [11:0]   sprite_rgb;
    logic [18:0]   bg_addr;
    logic [11:0]   bg_rgb;

    modport master (
        output board_addr,
        input  board_data,
        output sprite_addr,
        input  sprite_rgb,
        output bg_addr,
        input  bg_rgb
    );

    modport slave (
        input  board_addr,
        output board_data,
        input  sprite_addr,
        output sprite_rgb,
        input  bg_addr,
        output bg_rgb
    );
endinterface

// File: rtl/vga_grid_ctrl.sv
// VGA raster generator that draws a GRID_N x GRID_N board of sprite tiles
// over a background image and tallies the board score once per frame.
// Pipeline: counters -> S1 (board lookup) -> S2 (sprite/bg lookup, score)
// -> S3 (pixel select). Pixel output lags the counter state by 3 clocks.
module vga_grid_ctrl #(
    parameter int          H_ACT     = 640,
    parameter int          H_FP      = 16,
    parameter int          H_SYN     = 96,
    parameter int          H_BP      = 48,
    parameter int          V_ACT     = 480,
    parameter int          V_FP      = 10,
    parameter int          V_SYN     = 2,
    parameter int          V_BP      = 33,
    parameter int          GRID_N    = 4,
    parameter int          TILE      = 90,
    parameter int          GAP       = 20,
    parameter int          ORG_X     = 40,
    parameter int          ORG_Y     = 30,
    parameter int          BASE      = 256,
    parameter int          AW        = 11,
    parameter int          MAX_EXP   = 11,
    parameter logic [11:0] EMPTY_RGB = 12'hFFF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   blank,
    vga_grid_ctrl_if.master        mem,
    output logic                   hs,
    output logic                   vs,
    output logic [3:0]             red,
    output logic [3:0]             green,
    output logic [3:0]             blue,
    output logic                   de,
    output logic                   frame_start,
    output logic [31:0]            score
);
    localparam int H_TOT = H_ACT + H_FP + H_SYN + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYN + V_BP;
    localparam int PITCH = TILE + GAP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int OW    = $clog2(PITCH);
    localparam int CW    = $clog2(GRID_N + 1);

    // Counter state and tile trackers (hon/von: inside the tile span,
    // hoff/voff: offset within the tile pitch).
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic          hon_q, hon_d, von_q, von_d;
    logic [OW-1:0] hoff_q, hoff_d, voff_q, voff_d;
    logic [CW-1:0] col_q, col_d, row_q, row_d;
    logic          line_end_s;

    // Decoded counter-state attributes.
    logic          in_tile_s, top_left_s, act_s, hs_s, vs_s, fs_s, sl_s;
    logic [AW-1:0] tile_addr_s;
    logic [18:0]   bg_s;

    // S1 registers.
    logic [AW-1:0] board_addr_q;
    logic [OW-1:0] tx1_q, ty1_q;
    logic          in1_q, tl1_q, de1_q, hs1_q, vs1_q, fs1_q, sl1_q;
    logic [18:0]   bg1_q;

    // S2 registers and decode.
    logic [OW-1:0] tx2_q, ty2_q;
    logic          in2_q, tl2_q, de2_q, hs2_q, vs2_q, fs2_q, sl2_q;
    logic [18:0]   bg_addr_q;
    logic [4:0]    e_s;
    logic [17:0]   sprite_addr_s;

    // S3 registers and pixel select.
    logic          in3_q, ez3_q, de3_q, hs3_q, vs3_q, fs3_q;
    logic [11:0]   rgb_s;

    // Score.
    logic [31:0]   acc_q, score_q;

    // Next-state for the raster counters and the incremental tile trackers.
    always_comb begin
        hcnt_d     = hcnt_q;
        vcnt_d     = vcnt_q;
        hon_d      = hon_q;
        hoff_d     = hoff_q;
        col_d      = col_q;
        von_d      = von_q;
        voff_d     = voff_q;
        row_d      = row_q;
        line_end_s = (hcnt_q == HW'(H_TOT - 1));

        if (line_end_s) begin
            hcnt_d = '0;
            if (vcnt_q == VW'(V_TOT - 1)) begin
                vcnt_d = '0;
            end else begin
                vcnt_d = vcnt_q + VW'(1);
            end
        end else begin
            hcnt_d = hcnt_q + HW'(1);
        end

        // Columns: start at ORG_X, step the column every PITCH pixels.
        if (hcnt_d == HW'(ORG_X)) begin
            hon_d  = 1'b1;
            hoff_d = '0;
            col_d  = '0;
        end else if (!hon_q || line_end_s) begin
            hon_d  = 1'b0;
            hoff_d = '0;
            col_d  = '0;
        end else if (hoff_q == OW'(PITCH - 1)) begin
            hoff_d = '0;
            if (col_q == CW'(GRID_N - 1)) begin
                hon_d = 1'b0;
                col_d = '0;
            end else begin
                hon_d = 1'b1;
                col_d = col_q + CW'(1);
            end
        end else begin
            hoff_d = hoff_q + OW'(1);
        end

        // Rows: same scheme, advanced only at the end of each line.
        if (!line_end_s) begin
            von_d  = von_q;
            voff_d = voff_q;
            row_d  = row_q;
        end else if (vcnt_d == VW'(ORG_Y)) begin
            von_d  = 1'b1;
            voff_d = '0;
            row_d  = '0;
        end else if (!von_q || (vcnt_d == '0)) begin
            von_d  = 1'b0;
            voff_d = '0;
            row_d  = '0;
        end else if (voff_q == OW'(PITCH - 1)) begin
            voff_d = '0;
            if (row_q == CW'(GRID_N - 1)) begin
                von_d = 1'b0;
                row_d = '0;
            end else begin
                von_d = 1'b1;
                row_d = row_q + CW'(1);
            end
        end else begin
            voff_d = voff_q + OW'(1);
        end
    end

    assign in_tile_s   = hon_q && von_q && (hoff_q < OW'(TILE)) && (voff_q < OW'(TILE));
    assign top_left_s  = in_tile_s && (hoff_q == '0) && (voff_q == '0);
    assign act_s       = (hcnt_q < HW'(H_ACT)) && (vcnt_q < VW'(V_ACT));
    assign hs_s        = !((hcnt_q >= HW'(H_ACT + H_FP)) && (hcnt_q < HW'(H_ACT + H_FP + H_SYN)));
    assign vs_s        = !((vcnt_q >= VW'(V_ACT + V_FP)) && (vcnt_q < VW'(V_ACT + V_FP + V_SYN)));
    assign fs_s        = (hcnt_q == '0) && (vcnt_q == '0);
    assign sl_s        = (hcnt_q == '0) && (vcnt_q == VW'(V_ACT));
    assign tile_addr_s = AW'(BASE) + AW'(row_q) * AW'(GRID_N) + AW'(col_q);
    assign bg_s        = 19'(vcnt_q) * 19'(H_ACT) + 19'(hcnt_q);

    // Counter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
            hon_q  <= 1'b0;
            hoff_q <= '0;
            col_q  <= '0;
            von_q  <= 1'b0;
            voff_q <= '0;
            row_q  <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            hon_q  <= hon_d;
            hoff_q <= hoff_d;
            col_q  <= col_d;
            von_q  <= von_d;
            voff_q <= voff_d;
            row_q  <= row_d;
        end
    end

    // S1: issue the board lookup and carry tile offsets and timing flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            board_addr_q <= '0;
            tx1_q <= '0;
            ty1_q <= '0;
            in1_q <= 1'b0;
            tl1_q <= 1'b0;
            de1_q <= 1'b0;
            hs1_q <= 1'b1;
            vs1_q <= 1'b1;
            fs1_q <= 1'b0;
            sl1_q <= 1'b0;
            bg1_q <= '0;
        end else begin
            board_addr_q <= in_tile_s ? tile_addr_s : board_addr_q;
            tx1_q <= hoff_q;
            ty1_q <= voff_q;
            in1_q <= in_tile_s;
            tl1_q <= top_left_s;
            de1_q <= act_s;
            hs1_q <= hs_s;
            vs1_q <= vs_s;
            fs1_q <= fs_s;
            sl1_q <= sl_s;
            bg1_q <= bg_s;
        end
    end

    // S2 decode: clamp the exponent and form the sprite address.
    assign e_s           = (mem.board_data > 5'(MAX_EXP)) ? 5'(MAX_EXP) : mem.board_data;
    assign sprite_addr_s = (e_s != 5'd0)
                         ? 18'(e_s - 5'd1) * 18'(TILE * TILE) + 18'(ty2_q) * 18'(TILE) + 18'(tx2_q)
                         : 18'd0;

    // S2: drive the background address aligned with the sprite address.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx2_q     <= '0;
            ty2_q     <= '0;
            in2_q     <= 1'b0;
            tl2_q     <= 1'b0;
            de2_q     <= 1'b0;
            hs2_q     <= 1'b1;
            vs2_q     <= 1'b1;
            fs2_q     <= 1'b0;
            sl2_q     <= 1'b0;
            bg_addr_q <= '0;
        end else begin
            tx2_q     <= tx1_q;
            ty2_q     <= ty1_q;
            in2_q     <= in1_q;
            tl2_q     <= tl1_q;
            de2_q     <= de1_q;
            hs2_q     <= hs1_q;
            vs2_q     <= vs1_q;
            fs2_q     <= fs1_q;
            sl2_q     <= sl1_q;
            bg_addr_q <= bg1_q;
        end
    end

    // S3: hold the selection controls that meet the ROM data.
    always_ff @(posedge clk) begin
        if (rst) begin
            in3_q <= 1'b0;
            ez3_q <= 1'b0;
            de3_q <= 1'b0;
            hs3_q <= 1'b1;
            vs3_q <= 1'b1;
            fs3_q <= 1'b0;
        end else begin
            in3_q <= in2_q;
            ez3_q <= (e_s == 5'd0);
            de3_q <= de2_q;
            hs3_q <= hs2_q;
            vs3_q <= vs2_q;
            fs3_q <= fs2_q;
        end
    end

    // Score: add 2^e at each tile's top-left pixel; publish at frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= 32'd0;
            score_q <= 32'd0;
        end else if (sl2_q) begin
            acc_q   <= 32'd0;
            score_q <= acc_q;
        end else if (tl2_q && (e_s != 5'd0)) begin
            acc_q   <= acc_q + (32'd1 << e_s);
            score_q <= score_q;
        end else begin
            acc_q   <= acc_q;
            score_q <= score_q;
        end
    end

    // Final pixel select; the ROM data arrives this cycle, so this is a mux.
    always_comb begin
        rgb_s = 12'h000;
        if (!de3_q || blank) begin
            rgb_s = 12'h000;
        end else if (!in3_q) begin
            rgb_s = mem.bg_rgb;
        end else if (ez3_q) begin
            rgb_s = EMPTY_RGB;
        end else begin
            rgb_s = mem.sprite_rgb;
        end
    end

    assign mem.board_addr  = board_addr_q;
    assign mem.sprite_addr = sprite_addr_s;
    assign mem.bg_addr     = bg_addr_q;
    assign red             = rgb_s[11:8];
    assign green           = rgb_s[7:4];
    assign blue            = rgb_s[3:0];
    assign hs              = hs3_q;
    assign vs              = vs3_q;
    assign de              = de3_q;
    assign frame_start     = fs3_q;
    assign score           = score_q;
endmodule

// File: tb/tb_vga_grid_ctrl.sv
// Scoreboard bench for vga_grid_ctrl on a reduced raster (80x56 total,
// 64x48 visible, 8-pixel tiles with 4-pixel gaps, origin (6,2)).
module tb_vga_grid_ctrl;
    localparam int H_ACT = 64, H_FP = 4, H_SYN = 8, H_BP = 4;
    localparam int V_ACT = 48, V_FP = 2, V_SYN = 2, V_BP = 4;
    localparam int H_TOT = 80;
    localparam int FR    = 80 * 56;
    localparam int AW    = 11;

    localparam int K_BA = 0, K_SA = 1, K_RGB = 2, K_HS = 3, K_VS = 4, K_DE = 5, K_FS = 6, K_SC = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        blank = 1'b0;
    logic        hs, vs, de, frame_start;
    logic [3:0]  red, green, blue;
    logic [31:0] score;
    logic [4:0]  bmem [0:2047];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        int          at;
        int          kind;
        logic [31:0] v;
    } exp_t;
    exp_t sbq[$];

    vga_grid_ctrl_if #(.AW(AW)) mem_if ();

    vga_grid_ctrl #(
        .H_ACT(H_ACT), .H_FP(H_FP), .H_SYN(H_SYN), .H_BP(H_BP),
        .V_ACT(V_ACT), .V_FP(V_FP), .V_SYN(V_SYN), .V_BP(V_BP),
        .GRID_N(4), .TILE(8), .GAP(4), .ORG_X(6), .ORG_Y(2),
        .BASE(256), .AW(AW), .MAX_EXP(11), .EMPTY_RGB(12'hFFF)
    ) dut (
        .clk(clk), .rst(rst), .blank(blank), .mem(mem_if),
        .hs(hs), .vs(vs), .red(red), .green(green), .blue(blue),
        .de(de), .frame_start(frame_start), .score(score)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] spf(input logic [17:0] a);
        return a[11:0] ^ 12'h5A5;
    endfunction

    function automatic logic [11:0] bgf(input logic [18:0] a);
        return a[11:0] ^ 12'hC3C;
    endfunction

    // Synchronous memory models: data one clock after the address.
    always @(posedge clk) begin
        mem_if.board_data <= bmem[mem_if.board_addr];
        mem_if.sprite_rgb <= spf(mem_if.sprite_addr);
        mem_if.bg_rgb     <= bgf(mem_if.bg_addr);
    end

    function automatic string kname(input int k);
        case (k)
            K_BA:    return "board_addr";
            K_SA:    return "sprite_addr";
            K_RGB:   return "rgb";
            K_HS:    return "hs";
            K_VS:    return "vs";
            K_DE:    return "de";
            K_FS:    return "frame_start";
            K_SC:    return "score";
            default: return "unknown";
        endcase
    endfunction

    function automatic logic [31:0] actual_of(input int k);
        case (k)
            K_BA:    return 32'(mem_if.board_addr);
            K_SA:    return 32'(mem_if.sprite_addr);
            K_RGB:   return 32'({red, green, blue});
            K_HS:    return 32'(hs);
            K_VS:    return 32'(vs);
            K_DE:    return 32'(de);
            K_FS:    return 32'(frame_start);
            K_SC:    return score;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic push_exp(input int at, input int kind, input logic [31:0] v);
        exp_t e;
        e.at   = at;
        e.kind = kind;
        e.v    = v;
        sbq.push_back(e);
    endtask

    // Expectation for counter state (x,y) of frame f after the release at t0,
    // observed lat clocks later.
    task automatic pix(input int t0, input int f, input int x, input int y,
                       input int lat, input int kind, input logic [31:0] v);
        push_exp(t0 + f * FR + y * H_TOT + x + lat, kind, v);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic reset_state_checks(input int at);
        push_exp(at, K_HS, 32'd1);
        push_exp(at, K_VS, 32'd1);
        push_exp(at, K_DE, 32'd0);
        push_exp(at, K_FS, 32'd0);
        push_exp(at, K_SC, 32'd0);
        push_exp(at, K_RGB, 32'd0);
    endtask

    // Monitor: compare every expectation that falls due this cycle.
    initial begin
        logic [31:0] act;
        forever begin
            @(negedge clk);
            for (int i = sbq.size() - 1; i >= 0; i--) begin
                if (sbq[i].at == cyc) begin
                    act = actual_of(sbq[i].kind);
                    checks++;
                    if (act !== sbq[i].v) begin
                        failures++;
                        $display("FAIL %s at cycle %0d: got %0h, expected %0h",
                                 kname(sbq[i].kind), cyc, act, sbq[i].v);
                    end
                    sbq.delete(i);
                end
            end
        end
    end

    // Stimulus: board contents, blank, reset pulses and expected responses.
    initial begin
        int t0;
        int t1;
        int ts;
        for (int i = 0; i < 2048; i++) bmem[i] = 5'd0;
        for (int i = 0; i < 16; i++) bmem[256 + i] = 5'd1;
        bmem[256] = 5'd3;
        bmem[257] = 5'd0;
        bmem[258] = 5'd20;

        wait_until(3);
        reset_state_checks(cyc + 1);
        wait_until(6);
        rst = 1'b0;
        t0  = cyc;

        // Frame 0: timing, addressing, pixel selection, first score.
        push_exp(t0 + 2, K_FS, 32'd0);
        push_exp(t0 + 3, K_FS, 32'd1);
        push_exp(t0 + 3, K_DE, 32'd1);
        push_exp(t0 + 4, K_FS, 32'd0);
        pix(t0, 0,  6,  2, 1, K_BA, 32'd256);
        pix(t0, 0, 18,  2, 1, K_BA, 32'd257);
        pix(t0, 0, 18, 26, 1, K_BA, 32'd265);
        pix(t0, 0, 42, 38, 1, K_BA, 32'd271);
        pix(t0, 0,  7,  3, 2, K_SA, 32'd137);
        pix(t0, 0,  7,  3, 3, K_RGB, 32'(spf(18'd137)));
        pix(t0, 0, 13,  9, 3, K_RGB, 32'(spf(18'd191)));
        pix(t0, 0, 14,  2, 3, K_RGB, 32'(bgf(19'd142)));
        pix(t0, 0, 16,  2, 3, K_RGB, 32'(bgf(19'd144)));
        pix(t0, 0,  5,  2, 3, K_RGB, 32'(bgf(19'd133)));
        pix(t0, 0,  6, 10, 3, K_RGB, 32'(bgf(19'd646)));
        pix(t0, 0, 19,  3, 3, K_RGB, 32'h0000_0FFF);
        pix(t0, 0, 31,  3, 2, K_SA, 32'd649);
        pix(t0, 0, 31,  3, 3, K_RGB, 32'(spf(18'd649)));
        pix(t0, 0, 63,  5, 3, K_DE, 32'd1);
        pix(t0, 0, 64,  5, 3, K_DE, 32'd0);
        pix(t0, 0, 64,  5, 3, K_RGB, 32'd0);
        pix(t0, 0, 67,  5, 3, K_HS, 32'd1);
        pix(t0, 0, 68,  5, 3, K_HS, 32'd0);
        pix(t0, 0, 75,  5, 3, K_HS, 32'd0);
        pix(t0, 0, 76,  5, 3, K_HS, 32'd1);
        pix(t0, 0,  0, 49, 3, K_VS, 32'd1);
        pix(t0, 0,  0, 50, 3, K_VS, 32'd0);
        pix(t0, 0,  0, 51, 3, K_VS, 32'd0);
        pix(t0, 0,  0, 52, 3, K_VS, 32'd1);
        pix(t0, 0,  0, 48, 2, K_SC, 32'd0);
        pix(t0, 0,  0, 48, 3, K_SC, 32'd2082);

        // Frame 1: every tile exponent 1.
        wait_until(t0 + 4000);
        for (int i = 0; i < 16; i++) bmem[256 + i] = 5'd1;
        pix(t0, 1, 0,  0, 2, K_FS, 32'd0);
        pix(t0, 1, 0,  0, 3, K_FS, 32'd1);
        pix(t0, 1, 0, 48, 3, K_SC, 32'd32);

        // Frame 2: tile 5 at exponent 11, output blanked.
        wait_until(t0 + FR + 4000);
        bmem[261] = 5'd11;
        wait_until(t0 + 2 * FR - 100);
        blank = 1'b1;
        pix(t0, 2,  7,  3, 3, K_RGB, 32'd0);
        pix(t0, 2, 16,  2, 3, K_RGB, 32'd0);
        pix(t0, 2,  7,  3, 3, K_DE, 32'd1);
        pix(t0, 2, 67,  5, 3, K_HS, 32'd1);
        pix(t0, 2, 68,  5, 3, K_HS, 32'd0);
        pix(t0, 2,  0, 50, 3, K_VS, 32'd0);
        pix(t0, 2,  0, 48, 3, K_SC, 32'd2078);
        wait_until(t0 + 3 * FR - 100);
        blank = 1'b0;

        // Frame 3: reset pulse at line 20, then one full frame.
        wait_until(t0 + 3 * FR + 20 * H_TOT);
        rst = 1'b1;
        ts  = cyc;
        reset_state_checks(ts + 2);
        wait_until(ts + 4);
        rst = 1'b0;
        t1  = cyc;
        push_exp(t1 + 2, K_FS, 32'd0);
        push_exp(t1 + 3, K_FS, 32'd1);
        push_exp(t1 + 3, K_DE, 32'd1);
        pix(t1, 0, 6,  2, 1, K_BA, 32'd256);
        pix(t1, 0, 0, 48, 2, K_SC, 32'd0);
        pix(t1, 0, 0, 48, 3, K_SC, 32'd2078);

        wait_until(t1 + 48 * H_TOT + 10);
        checks++;
        if (score !== 32'd2078) begin
            failures++;
            $display("FAIL score at cycle %0d: got %0h, expected %0h", cyc, score, 32'd2078);
        end
        checks++;
        if (de !== 1'b0) begin
            failures++;
            $display("FAIL de at cycle %0d: got %0h, expected 0", cyc, de);
        end
        checks++;
        if (vs !== 1'b1) begin
            failures++;
            $display("FAIL vs at cycle %0d: got %0h, expected 1", cyc, vs);
        end
        checks++;
        if (frame_start !== 1'b0) begin
            failures++;
            $display("FAIL frame_start at cycle %0d: got %0h, expected 0", cyc, frame_start);
        end
        checks++;
        if ({red, green, blue} !== 12'h000) begin
            failures++;
            $display("FAIL rgb at cycle %0d: got %0h, expected 0", cyc, {red, green, blue});
        end
        for (int i = 0; i < sbq.size(); i++) begin
            checks++;
            failures++;
            $display("FAIL %s never compared (due at cycle %0d, expected %0h)",
                     kname(sbq[i].kind), sbq[i].at, sbq[i].v);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_grid_ctrl.md
VGA_GRID_CTRL -- requirements
Module: vga_grid_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  H_ACT 640, visible pixels per line
  H_FP 16, horizontal front porch
  H_SYN 96, horizontal sync width
  H_BP 48, horizontal back porch
  V_ACT 480, visible lines
  V_FP 10, vertical front porch
  V_SYN 2, vertical sync width
  V_BP 33, vertical back porch
  GRID_N 4, tiles per row and per column
  TILE 90, tile edge in pixels
  GAP 20, spacing between tiles
  ORG_X 40, left edge of tile (0,0)
  ORG_Y 30, top edge of tile (0,0)
  BASE 256, board address of tile 0
  AW 11, board address width
  MAX_EXP 11, highest sprite exponent
  EMPTY_RGB 12'hFFF, fill colour for an empty tile
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  in  1  pixel clock; the only clock
  rst  in  1  synchronous, active-high reset
  blank  in  1  forces black output while high
  board_addr  out  AW  board RAM address
  board_data  in  5  tile exponent; valid 1 cycle after board_addr
  sprite_addr  out  18  sprite ROM address
  sprite_rgb  in  12  valid 1 cycle after sprite_addr
  bg_addr  out  19  background ROM address
  bg_rgb  in  12  valid 1 cycle after bg_addr
  hs  out  1  horizontal sync, active low
  vs  out  1  vertical sync, active low
  red  out  4  red component
  green  out  4  green component
  blue  out  4  blue component
  de  out  1  active-video flag
  frame_start  out  1  one-cycle pulse at pixel (0,0)
  score  out  32  board score of the last complete frame

Function
REQ-003 hcnt SHALL count 0..H_TOT-1 and wrap, where H_TOT = H_ACT+H_FP+H_SYN+H_BP.
REQ-004 vcnt SHALL increment when hcnt wraps and SHALL wrap at V_TOT-1, where V_TOT is the sum of the four V_* parameters.
REQ-005 Active video SHALL be hcnt<H_ACT && vcnt<V_ACT; pixel x = hcnt, y = vcnt.
REQ-006 hs SHALL be low when hcnt is in [H_ACT+H_FP, H_ACT+H_FP+H_SYN); vs SHALL be low when vcnt is in [V_ACT+V_FP, V_ACT+V_FP+V_SYN).
REQ-007 Tile (r,c) SHALL cover x in [ORG_X+c*(TILE+GAP), ORG_X+c*(TILE+GAP)+TILE) and the same form in y; bounds are half-open (exactly TILE x TILE pixels).
REQ-008 The tile index, the tile-local offsets tx and ty, and in-tile membership SHALL be produced by incremental counters; no divide or modulo hardware is permitted.
REQ-009 Pipeline stage S1 (cycle after the counter state) SHALL drive board_addr = BASE + r*GRID_N + c for in-tile pixels, register tx, ty and in-tile, and drive bg_addr = y*H_ACT + x one stage later (S2) so all data align.
REQ-010 Stage S2 SHALL clamp e = min(board_data, MAX_EXP) and drive sprite_addr = (e-1)*TILE*TILE + ty*TILE + tx when e>0.
REQ-011 Stage S3 pixel selection:
  - not de, or blank, gives black
  - not in a tile gives bg_rgb
  - e==0 gives EMPTY_RGB
  - otherwise gives sprite_rgb
REQ-012 hs, vs, de and frame_start SHALL be delayed 3 cycles so they align with red/green/blue; total pixel latency is 3 clocks.
REQ-013 Score: an accumulator SHALL add 2^e (0 if e==0) once per tile, at that tile's top-left pixel in S2.
REQ-014 At delayed (vcnt==V_ACT, hcnt==0), score SHALL load the accumulator and the accumulator SHALL clear in the same cycle.
REQ-015 Accumulator width SHALL be 32 bits and SHALL wrap on overflow; score SHALL be held constant between loads.

Reset
REQ-016 While rst is high:
  - hcnt, vcnt, accumulator and score SHALL be 0
  - all pipeline valid and in-tile bits SHALL clear
  - hs and vs SHALL be 1; rgb, de and frame_start SHALL be 0
REQ-017 Reset asserted mid-frame SHALL restart at (0,0) on the first cycle after release, with no partial-frame score load; frame_start SHALL pulse 3 cycles after release.

Verification
REQ-018 Defaults, run 2 frames -> hcnt period 800, vcnt period 525; hs low for 96 clocks starting at hcnt=656; vs low on lines 490-491; frame_start every 420000 clocks.
REQ-019 Pixel (40,30) -> board_addr=256 at S1. Pixel (150,30) -> 257. Pixel (130,30) -> not in tile, bg_rgb output. Pixel (150,250) -> 265. Pixel (370,360) -> 271.
REQ-020 board_data=3 at tile (0,0), pixel (41,31) -> sprite_addr = 2*8100 + 1*90 + 1 = 16291; rgb equals sprite_rgb exactly 3 cycles after the counter state.
REQ-021 board_data=0 -> EMPTY_RGB output; board_data=20 -> treated as 11; blank=1 -> rgb=0 while hs and vs are unaffected.
REQ-022 All 16 tiles set to exponent 1 -> score=32 after the first full frame. Change tile 5 to exponent 11 -> score=2078 one frame later.
REQ-023 rst pulse at line 200 -> counters at 0 on the next cycle; score keeps its reset value 0 until a full frame completes.
